uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns a UART byte stream of ASCII hex commands into
// register-bus strobes.
//   W<addr><data><EOL>  -> one-cycle WriteStrobe_o with Address_o/WriteData_o
//   R<addr><EOL>        -> one-cycle ReadStrobe_o with Address_o
// Spaces are ignored everywhere. A malformed line gives one Error_o pulse,
// and the rest of the line is dropped until the next CR or LF.
module uart_cmd_parser #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Strobe_i,
  input  logic [7:0]               Data_i,
  output logic                     WriteStrobe_o,
  output logic                     ReadStrobe_o,
  output logic [ADDRESS_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0]    WriteData_o,
  output logic                     Error_o
);

  localparam int NA   = ADDRESS_WIDTH / 4;
  localparam int ND   = DATA_WIDTH / 4;
  localparam int MAXD = (NA > ND) ? NA : ND;
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW-1:0] NA_LAST = CW'(NA - 1);
  localparam logic [CW-1:0] ND_LAST = CW'(ND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_TERM,
    S_DISCARD
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_acc_q, addr_acc_d;
  logic [DATA_WIDTH-1:0]    data_acc_q, data_acc_d;
  logic                     op_write_q, op_write_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     wr_stb_q, wr_stb_d;
  logic                     rd_stb_q, rd_stb_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     err_q, err_d;

  logic       is_digit, is_alpha_hex, is_hex, is_eol, is_space, is_w, is_r;
  logic [3:0] nibble;

  // Classify the incoming byte and convert a hex character to its value.
  always_comb begin
    is_digit     = (Data_i >= 8'h30) && (Data_i <= 8'h39);
    is_alpha_hex = ((Data_i >= 8'h41) && (Data_i <= 8'h46)) ||
                   ((Data_i >= 8'h61) && (Data_i <= 8'h66));
    is_hex       = is_digit || is_alpha_hex;
    is_eol       = (Data_i == 8'h0D) || (Data_i == 8'h0A);
    is_space     = (Data_i == 8'h20);
    is_w         = (Data_i == 8'h57) || (Data_i == 8'h77);
    is_r         = (Data_i == 8'h52) || (Data_i == 8'h72);
    // 'A'/'a' have low nibble 1, so letters map to low nibble + 9.
    nibble       = is_digit ? Data_i[3:0] : (Data_i[3:0] + 4'd9);
  end

  // Line parser: next state, accumulators, and registered output strobes.
  always_comb begin
    state_d    = state_q;
    addr_acc_d = addr_acc_q;
    data_acc_d = data_acc_q;
    op_write_d = op_write_q;
    cnt_d      = cnt_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    address_d  = address_q;
    wdata_d    = wdata_q;
    err_d      = 1'b0;

    if (Strobe_i && !is_space) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_w || is_r) begin
            addr_acc_d = '0;
            data_acc_d = '0;
            op_write_d = is_w;
            cnt_d      = '0;
            state_d    = S_ADDR;
          end else if (!is_eol) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_ADDR: begin
          if (is_hex) begin
            addr_acc_d = (addr_acc_q << 4) | ADDRESS_WIDTH'(nibble);
            if (cnt_q == NA_LAST) begin
              cnt_d   = '0;
              state_d = op_write_q ? S_DATA : S_TERM;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = is_eol ? S_IDLE : S_DISCARD;
          end
        end
        S_DATA: begin
          if (is_hex) begin
            data_acc_d = (data_acc_q << 4) | DATA_WIDTH'(nibble);
            if (cnt_q == ND_LAST) begin
              cnt_d   = '0;
              state_d = S_TERM;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = is_eol ? S_IDLE : S_DISCARD;
          end
        end
        S_TERM: begin
          if (is_eol) begin
            address_d = addr_acc_q;
            if (op_write_q) begin
              wdata_d  = data_acc_q;
              wr_stb_d = 1'b1;
            end else begin
              rd_stb_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_eol) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything, even mid-line.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_acc_q <= '0;
      data_acc_q <= '0;
      op_write_q <= 1'b0;
      cnt_q      <= '0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_acc_q <= addr_acc_d;
      data_acc_q <= data_acc_d;
      op_write_q <= op_write_d;
      cnt_q      <= cnt_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign WriteStrobe_o = wr_stb_q;
  assign ReadStrobe_o  = rd_stb_q;
  assign Address_o     = address_q;
  assign WriteData_o   = wdata_q;
  assign Error_o       = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: each vector is one clock of input
// plus the outputs expected just after that clock edge.
module tb_uart_cmd_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Strobe_i;
  logic [7:0] Data_i;
  logic       WriteStrobe_o;
  logic       ReadStrobe_o;
  logic [7:0] Address_o;
  logic [7:0] WriteData_o;
  logic       Error_o;

  uart_cmd_parser #(
    .ADDRESS_WIDTH(8),
    .DATA_WIDTH   (8)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Strobe_i     (Strobe_i),
    .Data_i       (Data_i),
    .WriteStrobe_o(WriteStrobe_o),
    .ReadStrobe_o (ReadStrobe_o),
    .Address_o    (Address_o),
    .WriteData_o  (WriteData_o),
    .Error_o      (Error_o)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       stb;
    logic [7:0] d;
    logic       wr;
    logic       rd;
    logic       err;
    logic [7:0] addr;
    logic [7:0] wd;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cur_addr;
  logic [7:0] cur_wd;
  int         checks;
  int         errors;

  task automatic push(input logic s, input logic [7:0] d,
                      input logic w, input logic r, input logic e);
    vec_t v;
    v.stb = s; v.d = d; v.wr = w; v.rd = r; v.err = e;
    v.addr = cur_addr; v.wd = cur_wd;
    vecs.push_back(v);
  endtask

  // Strobed printable characters that should produce no pulse.
  task automatic bytes(input string s);
    for (int i = 0; i < s.len(); i++) push(1'b1, s[i], 1'b0, 1'b0, 1'b0);
  endtask

  // Idle cycles with garbage on Data_i, which must be ignored.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'h57, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic compare(input string name, input vec_t v);
    checks++;
    if (WriteStrobe_o !== v.wr || ReadStrobe_o !== v.rd || Error_o !== v.err ||
        Address_o !== v.addr || WriteData_o !== v.wd) begin
      errors++;
      $display("FAIL %s: got wr=%b rd=%b err=%b addr=%h wd=%h, expected wr=%b rd=%b err=%b addr=%h wd=%h",
               name, WriteStrobe_o, ReadStrobe_o, Error_o, Address_o, WriteData_o,
               v.wr, v.rd, v.err, v.addr, v.wd);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge Clock);
    Strobe_i = v.stb;
    Data_i   = v.d;
    @(posedge Clock);
    #1;
    compare(name, v);
  endtask

  vec_t hv;

  initial begin
    checks   = 0;
    errors   = 0;
    Reset    = 1'b1;
    Strobe_i = 1'b0;
    Data_i   = 8'h00;

    cur_addr = 8'h00;
    cur_wd   = 8'h00;

    // "W3A5C\r"
    bytes("W3A5C");
    cur_addr = 8'h3A; cur_wd = 8'h5C;
    push(1'b1, CR, 1'b1, 1'b0, 1'b0);
    gap(1);
    // "r ff\n" back-to-back, data must stay 5C
    bytes("r ff");
    cur_addr = 8'hFF;
    push(1'b1, LF, 1'b0, 1'b1, 1'b0);
    gap(2);
    // "W12\r" short write: error on EOL, nothing changes
    bytes("W12");
    push(1'b1, CR, 1'b0, 1'b0, 1'b1);
    // "R01\r" accepted afterwards
    bytes("R01");
    cur_addr = 8'h01;
    push(1'b1, CR, 1'b0, 1'b1, 1'b0);
    // "X123\r" one error only, then "W0102\r"
    push(1'b1, "X", 1'b0, 1'b0, 1'b1);
    bytes("123");
    push(1'b1, CR, 1'b0, 1'b0, 1'b0);
    bytes("W0102");
    cur_wd = 8'h02;
    push(1'b1, CR, 1'b1, 1'b0, 1'b0);
    // "W12345\r" extra digit: error on '5', silent EOL
    bytes("W1234");
    push(1'b1, "5", 1'b0, 1'b0, 1'b1);
    push(1'b1, CR, 1'b0, 1'b0, 1'b0);
    // blank lines
    push(1'b1, CR, 1'b0, 1'b0, 1'b0);
    push(1'b1, LF, 1'b0, 1'b0, 1'b0);
    push(1'b1, LF, 1'b0, 1'b0, 1'b0);
    push(1'b0, CR, 1'b0, 1'b0, 1'b0);
    // lowercase command, mixed-case hex
    bytes("wAbcD");
    cur_addr = 8'hAB; cur_wd = 8'hCD;
    push(1'b1, CR, 1'b1, 1'b0, 1'b0);
    // EOL inside the address field
    bytes("R1");
    push(1'b1, LF, 1'b0, 1'b0, 1'b1);
    // spaces everywhere
    bytes("W 1 2 3 4 ");
    cur_addr = 8'h12; cur_wd = 8'h34;
    push(1'b1, CR, 1'b1, 1'b0, 1'b0);
    // extra digit after a complete read, separated by a space
    bytes("R12 ");
    push(1'b1, "3", 1'b0, 1'b0, 1'b1);
    push(1'b1, CR, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    hv = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    compare("reset_state", hv);
    @(negedge Clock);
    Reset = 1'b0;

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset in the middle of "W3A"; outputs are 12/34 before it.
    hv = '{1'b1, "W", 1'b0, 1'b0, 1'b0, 8'h12, 8'h34}; apply("mid_W", hv);
    hv.d = "3";                                      apply("mid_3", hv);
    hv.d = "A";                                      apply("mid_A", hv);
    @(negedge Clock);
    Strobe_i = 1'b0;
    #2 Reset = 1'b1;
    #1;
    hv = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    compare("async_reset", hv);
    @(negedge Clock);
    Reset = 1'b0;
    // Remainder "5C\r" is now a malformed line
    hv = '{1'b1, "5", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}; apply("post_5", hv);
    hv = '{1'b1, "C", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; apply("post_C", hv);
    hv = '{1'b1, CR,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; apply("post_CR", hv);
    hv = '{1'b0, CR,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; apply("post_gap", hv);
    // Recovery: "R01\r"
    hv = '{1'b1, "R", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}; apply("rec_R", hv);
    hv.d = "0";                                        apply("rec_0", hv);
    hv.d = "1";                                        apply("rec_1", hv);
    hv = '{1'b1, CR,  1'b0, 1'b1, 1'b0, 8'h01, 8'h00}; apply("rec_CR", hv);
    hv = '{1'b0, CR,  1'b0, 1'b0, 1'b0, 8'h01, 8'h00}; apply("rec_gap", hv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
